// File: rtl/rx_byte_assembler_64_if.sv
// Receive-side bundle between the UART RX and the 8-to-64 block assembler.
// The master drives the UART strobes; the slave (assembler) drives the block outputs.
interface rx_byte_assembler_64_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rx_error;
  logic [63:0] data_out;
  logic        data_valid;
  logic        frame_error;
  logic [3:0]  byte_count;
  logic        idleOut;

  modport master (
    output rx_done, rx_data, rx_error,
    input  data_out, data_valid, frame_error, byte_count, idleOut
  );

  modport slave (
    input  rx_done, rx_data, rx_error,
    output data_out, data_valid, frame_error, byte_count, idleOut
  );
endinterface

// File: rtl/rx_byte_assembler_64.sv
// Collects eight UART bytes (first byte = MSB) into one 64-bit block, aborting a partial
// block on an inter-byte timeout or a UART error so block boundaries re-synchronise.
module rx_byte_assembler_64 #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                    clock,
  input logic                    reset,
  rx_byte_assembler_64_if.slave  bus
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e            state_q, state_d;
  logic [63:0]       shift_reg_q, shift_reg_d;
  logic [3:0]        byte_count_q, byte_count_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [63:0]       data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_error_q, frame_error_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      shift_reg_q   <= '0;
      byte_count_q  <= '0;
      timer_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_reg_q   <= shift_reg_d;
      byte_count_q  <= byte_count_d;
      timer_q       <= timer_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_reg_d   = shift_reg_q;
    byte_count_d  = byte_count_q;
    timer_d       = timer_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      // DONE behaves like IDLE so a byte arriving on the block boundary is kept.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.rx_done && !bus.rx_error) begin
          shift_reg_d  = {shift_reg_q[55:0], bus.rx_data};
          byte_count_d = byte_count_q + 4'd1;
          timer_d      = '0;
          state_d      = StCollect;
        end
      end
      StCollect: begin
        if (bus.rx_error) begin
          frame_error_d = 1'b1;
          shift_reg_d   = '0;
          byte_count_d  = '0;
          timer_d       = '0;
          state_d       = StIdle;
        end else if (bus.rx_done && byte_count_q == 4'd7) begin
          data_out_d   = {shift_reg_q[55:0], bus.rx_data};
          data_valid_d = 1'b1;
          shift_reg_d  = '0;
          byte_count_d = '0;
          timer_d      = '0;
          state_d      = StDone;
        end else if (bus.rx_done) begin
          shift_reg_d  = {shift_reg_q[55:0], bus.rx_data};
          byte_count_d = byte_count_q + 4'd1;
          timer_d      = '0;
        end else if (timer_q == TimerLast) begin
          frame_error_d = 1'b1;
          shift_reg_d   = '0;
          byte_count_d  = '0;
          timer_d       = '0;
          state_d       = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.byte_count  = byte_count_q;
  assign bus.idleOut     = (state_q == StIdle);

endmodule

// File: doc/rx_byte_assembler_64.md
# rx_byte_assembler_64

Deserializer that collects eight consecutive bytes from the UART receiver and presents them as one 64-bit block to the DES datapath input. It is the receive-side counterpart of the 64-to-8 transmit serializer. The first received byte is the most significant byte, so a block sent MSB-first by the transmit side is reconstructed bit-exact. An inter-byte timeout and a UART error input abort a partial block so the block boundary re-synchronises.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clock cycles allowed between bytes inside a block; must be ≥ 2.
- `clock` input, 1 bit: single system clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `rx_done` input, 1 bit: one-cycle pulse from the UART RX; `rx_data` is valid in that cycle.
- `rx_data` input, 8 bits: received byte.
- `rx_error` input, 1 bit: one-cycle pulse from the UART RX on a framing or stop-bit error.
- `data_out` output, 64 bits: last completed block; holds until the next block completes.
- `data_valid` output, 1 bit: one-cycle pulse when `data_out` updates.
- `frame_error` output, 1 bit: one-cycle pulse when a partial block is aborted.
- `byte_count` output, 4 bits: bytes collected in the current block, 0–7.
- `idleOut` output, 1 bit: high when the state is IDLE (combinational decode of the state).

## Operation
- States:
  - IDLE: no block in progress.
  - COLLECT: block in progress.
  - DONE: one-cycle completion state.
- Registers:
  - `shift_reg[63:0]`
  - `byte_count[3:0]`
  - `timer` (width `$clog2(TIMEOUT_CYCLES)`)
  - `data_out`, `data_valid`, `frame_error`
- Reset values (asynchronous, immediate): state IDLE, `shift_reg`=0, `byte_count`=0, `timer`=0, `data_out`=0, `data_valid`=0, `frame_error`=0, `idleOut`=1.
- Byte accept: `shift_reg` ← {`shift_reg[55:0]`, `rx_data`}; `byte_count` +1; `timer` ← 0.
- IDLE:
  - `rx_done` && !`rx_error`: accept the byte (`byte_count` becomes 1), go to COLLECT.
  - `rx_error` alone: ignored.
  - Any other input: stay in IDLE.
- COLLECT, checked in priority order:
  1. `rx_error` (regardless of `rx_done`): abort.
  2. `rx_done` with `byte_count`==7: `data_out` ← {`shift_reg[55:0]`, `rx_data`}; `data_valid` ← 1; `byte_count` ← 0; `shift_reg` ← 0; go to DONE.
  3. `rx_done` otherwise: accept the byte.
  4. `timer`==`TIMEOUT_CYCLES`-1: abort.
  5. Otherwise: `timer` +1.
- Abort: `frame_error` ← 1; `shift_reg`, `byte_count` and `timer` ← 0; go to IDLE; `data_out` is unchanged.
- DONE:
  - Always returns to IDLE next cycle; `data_valid` ← 0.
  - An `rx_done` in this cycle is accepted as byte 0 of the next block, exactly as in IDLE (`byte_count`=1, go to COLLECT). No byte is ever dropped on a block boundary.
- `data_valid` and `frame_error` are never high in the same cycle.
- Reset asserted mid-block discards the partial block and clears `data_out`.

## Timing
- 8th `rx_done` sampled at edge N → `data_out` updated and `data_valid`=1 after edge N; `data_valid`=0 after edge N+1; `idleOut`=1 after edge N+1.
- Latency from the last byte to valid data: 1 cycle, registered outputs.
- Timeout measured from the edge that accepted the latest byte: with no further `rx_done`, `frame_error` pulses after exactly `TIMEOUT_CYCLES` further edges.
- When `rx_done` and timer expiry coincide, the byte wins and the timer resets.
- `rx_done` back-to-back on consecutive cycles is supported: one byte per cycle, so a full block completes in 8 cycles.

## Test plan
- Reset, then bytes 01,23,45,67,89,AB,CD,EF spaced 100 cycles apart → `data_out`=0x0123456789ABCDEF with a single `data_valid` pulse one cycle after byte 8; `idleOut`=1 the cycle after that.
- Eight `rx_done` on consecutive cycles carrying 0xFF..0xF8 → `data_out`=0xFFFEFDFCFBFAF9F8 valid at cycle 9; then eight more bytes, the first arriving in the DONE cycle → second block assembled correctly with no byte lost.
- `TIMEOUT_CYCLES`=16: send 3 bytes, then idle → `frame_error` pulses 16 cycles after byte 3, `byte_count`=0, `data_out` unchanged; then 8 fresh bytes → a correct block.
- `rx_error` together with `rx_done` on byte 5 → abort, `frame_error`=1 for one cycle, no `data_valid`; `rx_error` in IDLE → no effect.
- Assert `reset` after 4 bytes → all outputs return to reset values immediately, without waiting for a clock edge; a subsequent full block → correct `data_out`.
- `TIMEOUT_CYCLES`=16: `rx_done` exactly on the expiry cycle → byte accepted, no `frame_error`, timer restarts.
